// File: rtl/conv_pkg.sv
// Shared defaults for the convolution datapath and helpers that size the
// adder tree (reduction depth and element count at each level).
package conv_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRAC_BIT    = 8;
    localparam int KERN_DIM    = 5;
    localparam int KERNEL_SIZE = KERN_DIM * KERN_DIM;

    function automatic int calc_levels(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Number of elements entering reduction level lvl (level 0 sees all n).
    function automatic int level_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

endpackage

// File: rtl/adder_level.sv
// One registered reduction level: adjacent pairs are summed with one bit of
// growth; an odd trailing element is sign-extended and passed through.
module adder_level #(
    parameter  int N_IN  = 2,
    parameter  int W_IN  = 16,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int W_OUT = W_IN + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ce,
    input  logic [N_IN*W_IN-1:0]   in_data,
    output logic [N_OUT*W_OUT-1:0] out_data
);

    logic [N_OUT*W_OUT-1:0] next_data;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        logic [W_OUT-1:0] a;
        assign a = {in_data[(2*j+1)*W_IN-1], in_data[2*j*W_IN +: W_IN]};
        if (2*j + 1 < N_IN) begin : g_add
            logic [W_OUT-1:0] b;
            assign b = {in_data[(2*j+2)*W_IN-1], in_data[(2*j+1)*W_IN +: W_IN]};
            assign next_data[j*W_OUT +: W_OUT] = a + b;
        end else begin : g_pass
            assign next_data[j*W_OUT +: W_OUT] = a;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   out_data <= '0;
        else if (ce) out_data <= next_data;
    end

endmodule

// File: rtl/adder_tree.sv
// Pipelined signed adder tree reducing one convolution window per cycle.
// Define ADDER_TREE_SAT_EN to clamp the result instead of wrapping it.
module adder_tree #(
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
    parameter int FRAC_BIT    = conv_pkg::FRAC_BIT
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] products,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             sum,
    output logic                              out_valid,
    output logic                              out_last,
    input  logic                              out_ready,
    output logic                              sat_flag
);

    localparam int LEVELS = conv_pkg::calc_levels(KERNEL_SIZE);
    localparam int FULL_W = DATA_WIDTH + LEVELS;

    logic              ce;
    logic [LEVELS:0]   vld_pipe;
    logic [LEVELS:0]   last_pipe;
    logic [FULL_W-1:0] full_sum;
    logic [DATA_WIDTH-1:0] sum_next;

    // Operands and result share one Q format, so no alignment shift exists.
    logic unused_frac;
    assign unused_frac = (FRAC_BIT >= 0);

    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN  = conv_pkg::level_count(KERNEL_SIZE, l);
        localparam int W_IN  = DATA_WIDTH + l;
        localparam int N_OUT = (N_IN + 1) / 2;
        logic [N_IN*W_IN-1:0]       din;
        logic [N_OUT*(W_IN+1)-1:0]  dout;
        if (l == 0) begin : g_src
            assign din = products;
        end else begin : g_src
            assign din = g_lvl[l-1].dout;
        end
        adder_level #(.N_IN(N_IN), .W_IN(W_IN)) u_level (
            .clk      (clk),
            .rstn     (rstn),
            .ce       (ce),
            .in_data  (din),
            .out_data (dout)
        );
    end

    assign full_sum = g_lvl[LEVELS-1].dout;

    // Valid and last ride alongside the data; bit LEVELS is the output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (ce) begin
            vld_pipe  <= {vld_pipe[LEVELS-1:0], in_valid};
            last_pipe <= {last_pipe[LEVELS-1:0], in_last};
        end
    end

    assign out_valid = vld_pipe[LEVELS];
    assign out_last  = last_pipe[LEVELS];

`ifdef ADDER_TREE_SAT_EN
    logic [LEVELS:0] top_bits;
    logic            sat_next;

    // In range only when every bit above the result sign bit repeats it.
    assign top_bits = full_sum[FULL_W-1:DATA_WIDTH-1];
    assign sat_next = !((&top_bits) || !(|top_bits));

    always_comb begin
        sum_next = full_sum[DATA_WIDTH-1:0];
        if (sat_next)
            sum_next = full_sum[FULL_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   sat_flag <= 1'b0;
        else if (ce) sat_flag <= sat_next;
    end
`else
    logic unused_hi;
    assign unused_hi = ^full_sum[FULL_W-1:DATA_WIDTH];
    assign sum_next  = full_sum[DATA_WIDTH-1:0];
    assign sat_flag  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   sum <= '0;
        else if (ce) sum <= sum_next;
    end

endmodule

// File: tb/tb_adder_tree.sv
// Scoreboard bench for adder_tree: the driver pushes the reference result of
// every accepted window, an independent monitor pops and compares outputs.
module tb_adder_tree;

    localparam int KS = 25;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [KS*DW-1:0]  products = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     sum;
    logic              out_valid;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              sat_flag;

    adder_tree #(.KERNEL_SIZE(KS), .DATA_WIDTH(DW), .FRAC_BIT(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .products  (products),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sum       (sum),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] sum;
        logic          last;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: exact integer sum of the signed products, then clamp or wrap.
    function automatic exp_t model(input logic [KS*DW-1:0] p, input logic last);
        longint acc;
        longint maxv;
        longint minv;
        exp_t   e;
        acc  = 0;
        maxv = (longint'(1) <<< (DW-1)) - 1;
        minv = -(longint'(1) <<< (DW-1));
        for (int i = 0; i < KS; i++) acc += longint'($signed(p[i*DW +: DW]));
        e.last = last;
`ifdef ADDER_TREE_SAT_EN
        if (acc > maxv) begin
            acc = maxv; e.sat = 1'b1;
        end else if (acc < minv) begin
            acc = minv; e.sat = 1'b1;
        end else begin
            e.sat = 1'b0;
        end
`else
        e.sat = 1'b0;
`endif
        e.sum = acc[DW-1:0];
        return e;
    endfunction

    function automatic logic [KS*DW-1:0] fill(input logic [DW-1:0] v);
        logic [KS*DW-1:0] p;
        for (int i = 0; i < KS; i++) p[i*DW +: DW] = v;
        return p;
    endfunction

    function automatic logic [KS*DW-1:0] rand_win();
        logic [KS*DW-1:0] p;
        int mode;
        mode = $urandom_range(0, 3);
        for (int i = 0; i < KS; i++) begin
            logic [31:0] r;
            r = $urandom;
            case (mode)
                0:       p[i*DW +: DW] = r[DW-1:0];
                1:       p[i*DW +: DW] = {{(DW-8){r[7]}}, r[7:0]};
                2:       p[i*DW +: DW] = {1'b0, {(DW-1){1'b1}}} - DW'(r[3:0]);
                default: p[i*DW +: DW] = {1'b1, {(DW-1){1'b0}}} + DW'(r[3:0]);
            endcase
        end
        return p;
    endfunction

    // Monitor: pops on each output transfer and checks hold-stability on stalls.
    initial begin
        logic          hold;
        logic [DW-1:0] h_sum;
        logic          h_last;
        logic          h_sat;
        exp_t          e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_sum", sum, h_sum);
                    check("hold_last", out_last, h_last);
                    check("hold_sat", sat_flag, h_sat);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sum", sum, e.sum);
                        check("last", out_last, e.last);
                        check("sat", sat_flag, e.sat);
                    end
                end
                hold   = out_valid && !out_ready;
                h_sum  = sum;
                h_last = out_last;
                h_sat  = sat_flag;
            end
        end
    end

    task automatic cyc(input logic v, input logic [KS*DW-1:0] p, input logic l,
                       input logic r, output logic acc);
        @(negedge clk);
        in_valid  = v;
        products  = p;
        in_last   = l;
        out_ready = r;
        #1;
        acc = v && in_ready && rstn;
        if (acc) sb.push_back(model(p, l));
    endtask

    task automatic drain();
        int   n;
        logic a;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            cyc(1'b0, '0, 1'b0, 1'b1, a);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) cyc(1'b0, '0, 1'b0, 1'b1, a);
    endtask

    task automatic latency_check(input logic [KS*DW-1:0] p, input string name);
        logic a;
        int   n;
        n = 0;
        cyc(1'b1, p, 1'b0, 1'b1, a);
        check({name, "_accept"}, a, 1);
        do begin
            cyc(1'b0, '0, 1'b0, 1'b1, a);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_latency"}, n, 6);
        drain();
    endtask

    initial begin
        logic             a;
        logic [KS*DW-1:0] mixed;
        int               issued;
        int               cycles;
        int               n;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        latency_check(fill(16'h0100), "ones");
        latency_check(fill(16'h7FFF), "max");
        for (int i = 0; i < KS; i++) mixed[i*DW +: DW] = (i < 12) ? 16'h0100 : 16'hFF00;
        latency_check(mixed, "mixed");
        latency_check(fill(16'h8000), "min");

        // A, B, C back to back, then stall the consumer for 3 cycles at A.
        cyc(1'b1, rand_win(), 1'b0, 1'b1, a);
        cyc(1'b1, rand_win(), 1'b0, 1'b1, a);
        cyc(1'b1, rand_win(), 1'b1, 1'b1, a);
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            n++;
        end while (!out_valid && n < 20);
        check("stall_a_arrived", out_valid, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("stall_in_ready", in_ready, 0);
        end
        drain();

        // Reset with windows in flight: nothing stale may come out afterwards.
        for (int k = 0; k < 8; k++) cyc(1'b1, rand_win(), k[0], 1'b1, a);
        @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        latency_check(fill(16'h0100), "post_rst");

        // Random traffic on both handshakes.
        issued = 0;
        cycles = 0;
        while (issued < 1000 && cycles < 20000) begin
            cyc($urandom_range(0, 9) < 7, rand_win(), $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) < 7, a);
            if (a) issued++;
            cycles++;
        end
        check("random_issued", issued, 1000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree.md
ADDER_TREE -- requirements
Module: adder_tree

Interface
REQ-001 Parameter KERNEL_SIZE, default 25, number of products summed per window (KERN_DIM*KERN_DIM).
REQ-002 Parameter DATA_WIDTH, default 16, width of each signed product and of the result.
REQ-003 Parameter FRAC_BIT, default 8, fractional bits of the shared fixed-point format; both operands and result use the same Q format.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 products  input  KERNEL_SIZE*DATA_WIDTH  packed signed products from multiplier; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_valid  input  1  products holds a valid window.
REQ-008 in_last  input  1  window is the last of a frame; travels with its data.
REQ-009 in_ready  output  1  block accepts a window this cycle.
REQ-010 sum  output  DATA_WIDTH  signed window sum, same Q format as products.
REQ-011 out_valid  output  1  sum is valid.
REQ-012 out_last  output  1  delayed copy of in_last for this sum.
REQ-013 out_ready  input  1  consumer accepts sum this cycle.
REQ-014 sat_flag  output  1  sum was clamped (valid only with out_valid).

Function
REQ-015 LEVELS = ceil(log2(KERNEL_SIZE)); pipeline SHALL be LEVELS adder-register stages plus one output register; latency LEVELS+1 cycles (6 at default) with no stall.
REQ-016 Each level SHALL sign-extend operands by 1 bit; an odd leftover element SHALL pass through registered unchanged (implicit +0).
REQ-017 Final full-precision sum width SHALL be DATA_WIDTH+LEVELS; no rounding or shift (formats match).
REQ-018 Global advance ce = !out_valid || out_ready; all data, valid and last registers SHALL update only when ce=1.
REQ-019 in_ready SHALL equal ce (combinational); a window transfers when in_valid && in_ready.
REQ-020 Bubbles (in_valid=0 with ce=1) SHALL propagate as valid=0 stages; data in invalid stages is don't-care.
REQ-021 Output SHALL hold sum, out_valid, out_last, sat_flag stable while out_valid && !out_ready.
REQ-022 Windows SHALL leave in acceptance order; none lost or duplicated under any out_ready pattern.
REQ-023 Throughput SHALL be one window per cycle while out_ready=1.

Reset
REQ-024 rstn low SHALL asynchronously clear all stage valid bits, last bits, out_valid, out_last, sat_flag and sum to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight windows; first output after release is the first window accepted after release.
REQ-026 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-027 Macro ADDER_TREE_SAT_EN defined: final sum SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and sat_flag=1 when clamping occurred.
REQ-028 Macro undefined: sum SHALL be the low DATA_WIDTH bits of the full sum (wrap) and sat_flag SHALL be constant 0; port list unchanged.

Structure
REQ-029 Shared package conv_pkg SHALL hold DATA_WIDTH, FRAC_BIT, KERN_DIM, KERNEL_SIZE defaults and a clog2-based LEVELS function.
REQ-030 One sub-module adder_level (one reduction level: N inputs to ceil(N/2) registered outputs with ce, width parameter) SHALL be instantiated LEVELS times via generate.

Verification
REQ-031 25 products of 0x0100, in_valid 1 cycle, out_ready=1 -> sum 0x1900, out_valid exactly 6 cycles later, sat_flag 0.
REQ-032 25 products of 0x7FFF -> SAT_EN: sum 0x7FFF, sat_flag 1; no macro: sum 0x7FE7, sat_flag 0.
REQ-033 12 products of 0x0100 and 13 of 0xFF00 -> sum 0xFF00 (-1.0); all 0x8000 with SAT_EN -> 0x8000, sat_flag 1.
REQ-034 Windows A,B,C back-to-back (in_last on C), out_ready low 3 cycles once A reaches output -> in_ready low while stalled, A held stable, then A,B,C emitted in order with out_last only on C.
REQ-035 rstn pulsed low for 1 cycle with 4 windows in flight -> out_valid 0 at once, no stale sums emitted; next accepted window emerges after 6 cycles.
REQ-036 Random in_valid/out_ready, 1000 windows, compared against reference model -> all sums, last flags and order match.
